// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the ADXL357 I2C target emulator.
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StMstrAck, StIgnore
  } tgt_state_e;

  localparam logic [7:0] REG_DEVID_AD  = 8'h00;
  localparam logic [7:0] REG_DEVID_MST = 8'h01;
  localparam logic [7:0] REG_PARTID    = 8'h02;
  localparam logic [7:0] REG_TEMP2     = 8'h06;
  localparam logic [7:0] REG_TEMP1     = 8'h07;
  localparam logic [7:0] REG_XDATA3    = 8'h08;
  localparam logic [7:0] REG_YDATA3    = 8'h0B;
  localparam logic [7:0] REG_ZDATA3    = 8'h0E;
  localparam logic [7:0] REG_RANGE     = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;

  localparam logic [7:0] ID_AD   = 8'hAD;
  localparam logic [7:0] ID_MST  = 8'h1D;
  localparam logic [7:0] ID_PART = 8'hED;

  localparam logic [7:0] RANGE_RST     = 8'h81;
  localparam logic [7:0] POWER_CTL_RST = 8'h01;

  // Byte idx 0..2 of a 20-bit sample, left-justified into 24 bits.
  function automatic logic [7:0] axis_byte(logic [19:0] v, logic [1:0] idx);
    case (idx)
      2'd0:    return v[19:12];
      2'd1:    return v[11:4];
      default: return {v[3:0], 4'h0};
    endcase
  endfunction

endpackage

// File: rtl/i2c_tgt_sync_filter.sv
// Two-flop synchronizer for one bus line, with an optional glitch filter
// compiled in by I2C_TGT_GLITCH_FILTER_EN.
module i2c_tgt_sync_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Bus lines idle high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(FILT_LEN - 1)) begin
      filt_q <= sync_q[1];
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q_o = filt_q;
`else
  assign q_o = sync_q[1];
`endif

endmodule

// File: rtl/i2c_target_adxl357_emu.sv
// I2C target emulating the ADXL357 register file; optional input glitch filter
// is enabled by defining I2C_TGT_GLITCH_FILTER_EN.
module i2c_target_adxl357_emu
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h1D,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [19:0] i_accx,
  input  logic [19:0] i_accy,
  input  logic [19:0] i_accz,
  input  logic [11:0] i_temp,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  output logic        o_sda_oe,
  output logic [7:0]  o_range,
  output logic [7:0]  o_power_ctl,
  output logic        o_busy,
  output logic        o_rd_done,
  output logic [3:0]  o_state
);

  logic scl_s, sda_s, scl_p_q, sda_p_q;

  i2c_tgt_sync_filter #(.FILT_LEN(FILT_LEN)) u_scl_sync (
    .clk_i(i_clk), .rst_i(i_rst), .d_i(i2c_scl), .q_o(scl_s)
  );
  i2c_tgt_sync_filter #(.FILT_LEN(FILT_LEN)) u_sda_sync (
    .clk_i(i_clk), .rst_i(i_rst), .d_i(i2c_sda), .q_o(sda_s)
  );

  tgt_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [6:0]  rx_q;
  logic [7:0]  tx_q, ptr_q, range_q, pwr_q;
  logic        rw_q, hit_q, nack_q, oe_q, busy_q, rd_done_q, rd_seen_q;
  logic [19:0] ax_q, ay_q, az_q;
  logic [11:0] tmp_q;

  logic       start, stop, scl_rise, scl_fall;
  logic [7:0] rx_nxt, cur_byte, nxt_byte;

  assign start    = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop     = scl_s & scl_p_q & ~sda_p_q & sda_s;
  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;
  assign rx_nxt   = {rx_q, sda_s};

  function automatic logic [7:0] reg_byte(logic [7:0] a);
    case (a)
      REG_DEVID_AD:              return ID_AD;
      REG_DEVID_MST:             return ID_MST;
      REG_PARTID:                return ID_PART;
      REG_TEMP2:                 return {4'h0, tmp_q[11:8]};
      REG_TEMP1:                 return tmp_q[7:0];
      8'h08, 8'h09, 8'h0A:       return axis_byte(ax_q, 2'(a - REG_XDATA3));
      8'h0B, 8'h0C, 8'h0D:       return axis_byte(ay_q, 2'(a - REG_YDATA3));
      8'h0E, 8'h0F, 8'h10:       return axis_byte(az_q, 2'(a - REG_ZDATA3));
      REG_RANGE:                 return range_q;
      REG_POWER_CTL:             return pwr_q;
      default:                   return 8'h00;
    endcase
  endfunction

  always_comb begin
    cur_byte = reg_byte(ptr_q);
    nxt_byte = reg_byte(ptr_q + 8'd1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      hit_q     <= 1'b0;
      nack_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
      rd_seen_q <= 1'b0;
      range_q   <= RANGE_RST;
      pwr_q     <= POWER_CTL_RST;
      ax_q      <= '0;
      ay_q      <= '0;
      az_q      <= '0;
      tmp_q     <= '0;
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
    end else begin
      scl_p_q   <= scl_s;
      sda_p_q   <= sda_s;
      rd_done_q <= 1'b0;
      if (start) begin
        state_q <= StAddr;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
      end else if (stop) begin
        state_q   <= StIdle;
        oe_q      <= 1'b0;
        busy_q    <= 1'b0;
        rd_done_q <= rd_seen_q;
        rd_seen_q <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          StAddr, StPtr, StWdata: begin
            rx_q  <= rx_nxt[6:0];
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == StAddr) begin
                rw_q  <= sda_s;
                hit_q <= (rx_nxt[7:1] == DEV_ADDR);
                if (rx_nxt[7:1] == DEV_ADDR) begin
                  busy_q <= 1'b1;
                  // Shadow the samples so a burst read is coherent.
                  if (sda_s) begin
                    ax_q  <= i_accx;
                    ay_q  <= i_accy;
                    az_q  <= i_accz;
                    tmp_q <= i_temp;
                  end
                end
              end else if (state_q == StPtr) begin
                ptr_q <= rx_nxt;
              end else if (ptr_q == REG_RANGE) begin
                range_q <= rx_nxt;
              end else if (ptr_q == REG_POWER_CTL) begin
                pwr_q <= rx_nxt;
              end
            end
          end
          StRdata:   cnt_q  <= cnt_q + 4'd1;
          StMstrAck: nack_q <= sda_s;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          StAddr: if (cnt_q == 4'd8) begin
            state_q <= hit_q ? StAddrAck : StIgnore;
            oe_q    <= hit_q;
          end
          StAddrAck: begin
            cnt_q <= '0;
            if (rw_q) begin
              state_q   <= StRdata;
              tx_q      <= cur_byte;
              oe_q      <= ~cur_byte[7];
              rd_seen_q <= 1'b1;
            end else begin
              state_q <= StPtr;
              oe_q    <= 1'b0;
            end
          end
          StPtr, StWdata: if (cnt_q == 4'd8) begin
            state_q <= (state_q == StPtr) ? StPtrAck : StWdataAck;
            oe_q    <= 1'b1;
          end
          StPtrAck, StWdataAck: begin
            if (state_q == StWdataAck) ptr_q <= ptr_q + 8'd1;
            state_q <= StWdata;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
          end
          StRdata: begin
            if (cnt_q == 4'd8) begin
              state_q <= StMstrAck;
              oe_q    <= 1'b0;
            end else begin
              tx_q <= {tx_q[6:0], 1'b0};
              oe_q <= ~tx_q[6];
            end
          end
          StMstrAck: begin
            if (!nack_q) begin
              ptr_q   <= ptr_q + 8'd1;
              tx_q    <= nxt_byte;
              oe_q    <= ~nxt_byte[7];
              cnt_q   <= '0;
              state_q <= StRdata;
            end else begin
              state_q <= StIgnore;
              oe_q    <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sda     = oe_q ? 1'b0 : 1'bz;
  assign o_sda_oe    = oe_q;
  assign o_range     = range_q;
  assign o_power_ctl = pwr_q;
  assign o_busy      = busy_q;
  assign o_rd_done   = rd_done_q;
  assign o_state     = state_q;

endmodule
